axi_simple_master: RTL and testbench

AXI4 initiator bridging a single-outstanding core memory port onto one master port of the AXI interconnect. Accepts one read or write request at a time, drives the AR/R or AW/W/B channels, and returns read data, a completion pulse and an error flag to the core. It is the initiator counterpart of the interconnect's slaves; a slave returning DECERR appears to the core as `err`.

---
 rtl/axi_simple_master_if.sv | 58 +++++
 rtl/axi_simple_master.sv | 177 +++++++++++++++++
 tb/tb_axi_simple_master.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_simple_master_if.sv
// AXI4 channel bundle between axi_simple_master and one interconnect master port.
interface axi_simple_master_if;
  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY,
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY,
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY
  );
endinterface

// File: rtl/axi_simple_master.sv
// Single-outstanding core port to AXI4 initiator. Define AXI_MASTER_LINE_FILL_EN to turn
// reads into 4-beat, 16-byte-aligned line fills; writes stay single-beat.
module axi_simple_master #(
  parameter logic [3:0] MASTER_ID = 4'd0
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic                       req,
  input  logic                       we,
  input  logic [31:0]                addr,
  input  logic [31:0]                wdata,
  input  logic [3:0]                 wstrb,
  output logic [31:0]                rdata,
  output logic                       rdata_valid,
  output logic                       done,
  output logic                       err,
  output logic                       busy,
  axi_simple_master_if.master        axi
);

  typedef enum logic [2:0] {StIdle, StRaddr, StRdata, StWreq, StWresp} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        rerr_q, rerr_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        rvalid_q, rvalid_d;
  logic        beat_err;
  logic        unused_ids;

`ifdef AXI_MASTER_LINE_FILL_EN
  logic [1:0]  beat_q, beat_d;
  // RLAST must land on exactly the fourth beat; counter sticks at 3 on overlong bursts.
  assign beat_err = axi.RLAST ? (beat_q != 2'd3) : (beat_q == 2'd3);
`else
  assign beat_err = !axi.RLAST;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rerr_d    = rerr_q;
    err_d     = err_q;
    done_d    = 1'b0;
    rvalid_d  = 1'b0;
`ifdef AXI_MASTER_LINE_FILL_EN
    beat_d    = beat_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req) begin
          addr_d    = addr;
          wdata_d   = wdata;
          wstrb_d   = wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          rerr_d    = 1'b0;
`ifdef AXI_MASTER_LINE_FILL_EN
          beat_d    = 2'd0;
`endif
          state_d   = we ? StWreq : StRaddr;
        end
      end
      StRaddr: begin
        if (axi.ARREADY) state_d = StRdata;
      end
      StRdata: begin
        if (axi.RVALID) begin
          rdata_d  = axi.RDATA;
          rvalid_d = 1'b1;
          rerr_d   = rerr_q | (axi.RRESP != 2'b00) | beat_err;
`ifdef AXI_MASTER_LINE_FILL_EN
          if (beat_q != 2'd3) beat_d = beat_q + 2'd1;
`endif
          if (axi.RLAST) begin
            done_d  = 1'b1;
            err_d   = rerr_d;
            state_d = StIdle;
          end
        end
      end
      StWreq: begin
        // AW and W complete independently; leave once both have been accepted.
        aw_done_d = aw_done_q | axi.AWREADY;
        w_done_d  = w_done_q | axi.WREADY;
        if (aw_done_d && w_done_d) state_d = StWresp;
      end
      StWresp: begin
        if (axi.BVALID) begin
          done_d  = 1'b1;
          err_d   = (axi.BRESP != 2'b00);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rerr_q    <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      rvalid_q  <= 1'b0;
`ifdef AXI_MASTER_LINE_FILL_EN
      beat_q    <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rerr_q    <= rerr_d;
      err_q     <= err_d;
      done_q    <= done_d;
      rvalid_q  <= rvalid_d;
`ifdef AXI_MASTER_LINE_FILL_EN
      beat_q    <= beat_d;
`endif
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rvalid_q;
  assign done        = done_q;
  assign err         = err_q;
  assign busy        = (state_q != StIdle);

  assign axi.ARID    = MASTER_ID;
  assign axi.ARSIZE  = 3'b010;
  assign axi.ARBURST = 2'b01;
`ifdef AXI_MASTER_LINE_FILL_EN
  assign axi.ARADDR  = {addr_q[31:4], 4'h0};
  assign axi.ARLEN   = 4'd3;
`else
  assign axi.ARADDR  = addr_q;
  assign axi.ARLEN   = 4'd0;
`endif
  assign axi.ARVALID = (state_q == StRaddr);
  assign axi.RREADY  = (state_q == StRdata);

  assign axi.AWID    = MASTER_ID;
  assign axi.AWADDR  = addr_q;
  assign axi.AWLEN   = 4'd0;
  assign axi.AWSIZE  = 3'b010;
  assign axi.AWBURST = 2'b01;
  assign axi.AWVALID = (state_q == StWreq) && !aw_done_q;
  assign axi.WDATA   = wdata_q;
  assign axi.WSTRB   = wstrb_q;
  assign axi.WLAST   = 1'b1;
  assign axi.WVALID  = (state_q == StWreq) && !w_done_q;
  assign axi.BREADY  = (state_q == StWresp);

  assign unused_ids = ^{axi.RID, axi.BID};

endmodule

// File: tb/tb_axi_simple_master.sv
// Bench for axi_simple_master: scripted AXI slave driven at negedges, transaction-level model
// of expected address, beats, error and completion timing.
module tb_axi_simple_master;
  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        rdata_valid, done, err, busy;

  axi_simple_master_if bus ();

  axi_simple_master #(.MASTER_ID(4'd0)) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .req         (req),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .done        (done),
    .err         (err),
    .busy        (busy),
    .axi         (bus.master)
  );

  always #5 ACLK = ~ACLK;

`ifdef AXI_MASTER_LINE_FILL_EN
  localparam bit LineFill = 1'b1;
`else
  localparam bit LineFill = 1'b0;
`endif
  localparam int LastBeat = LineFill ? 3 : 0;

  int n_cmp = 0;
  int n_bad = 0;

  // Slave read script: beat data/response, and which beat carries RLAST.
  logic [31:0] bd [6];
  logic [1:0]  br [6];
  int          last_idx;

  // Observations from the latest transaction.
  logic [31:0] o_araddr, o_awaddr, o_wdata;
  logic [3:0]  o_arlen, o_arid, o_awlen, o_awid, o_wstrb;
  logic [2:0]  o_arsize, o_awsize;
  logic [1:0]  o_arburst, o_awburst;
  logic        o_wlast, o_err, o_busy0;
  logic [31:0] o_rd [$];
  int          o_done, o_done_cyc, o_ar_rise, o_aw_cnt, o_split, o_viol;

  function automatic logic [31:0] exp_araddr(input logic [31:0] a);
    return LineFill ? {a[31:4], 4'h0} : a;
  endfunction

  function automatic logic exp_rerr();
    logic e;
    e = (last_idx != LastBeat);
    for (int i = 0; i <= last_idx; i++) if (br[i] != 2'b00) e = 1'b1;
    return e;
  endfunction

  function automatic int rd_mismatch();
    int n;
    n = 0;
    if (o_rd.size() != last_idx + 1) n++;
    for (int i = 0; i < o_rd.size() && i <= last_idx; i++) if (o_rd[i] !== bd[i]) n++;
    return n;
  endfunction

  task automatic fill_beats(input int li, input bit with_err);
    for (int i = 0; i < 6; i++) begin
      bd[i] = $urandom;
      br[i] = (with_err && $urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    end
    last_idx = li;
  endtask

  task automatic clear_obs();
    o_rd.delete();
    o_done = 0; o_done_cyc = -1; o_ar_rise = 0; o_aw_cnt = 0; o_split = 0; o_viol = 0;
    o_err = 1'b0; o_busy0 = 1'b0;
  endtask

  // Called at a negedge; rmode 0 = RVALID whenever possible, 1 = alternating, 2 = random.
  task automatic drive_read(input logic [31:0] a, input int ar_dly, input int rmode,
                            input bit toggle_req);
    int          beat;
    bit          ar_ok;
    logic        pv, prev_arv, rhs;
    logic [31:0] pa;
    beat = 0; ar_ok = 1'b0; pv = 1'b0; prev_arv = 1'b0; pa = '0;
    clear_obs();
    req = 1'b1; we = 1'b0; addr = a; wdata = $urandom; wstrb = 4'($urandom);
    for (int c = 0; c < 300; c++) begin
      @(negedge ACLK);
      if (c == 0) o_busy0 = busy;
      if (rdata_valid) o_rd.push_back(rdata);
      if (bus.AWVALID) o_aw_cnt++;
      if (bus.ARVALID && !prev_arv) o_ar_rise++;
      if (pv && (!bus.ARVALID || bus.ARADDR !== pa)) o_viol++;
      prev_arv = bus.ARVALID;
      if (done) begin
        o_done++; o_done_cyc = c; o_err = err;
        break;
      end
      bus.ARREADY = (c >= ar_dly) && !ar_ok;
      case (rmode)
        0:       bus.RVALID = ar_ok && (beat < 6);
        1:       bus.RVALID = ar_ok && (beat < 6) && (c % 2 == 0);
        default: bus.RVALID = ar_ok && (beat < 6) && ($urandom_range(0, 1) == 1);
      endcase
      bus.RDATA = bd[beat % 6];
      bus.RRESP = br[beat % 6];
      bus.RLAST = (beat == last_idx);
      rhs = bus.RVALID && bus.RREADY;
      if (bus.ARVALID && bus.ARREADY) begin
        ar_ok = 1'b1;
        o_araddr = bus.ARADDR; o_arlen = bus.ARLEN; o_arsize = bus.ARSIZE;
        o_arburst = bus.ARBURST; o_arid = bus.ARID;
      end
      pv = bus.ARVALID && !bus.ARREADY;
      pa = bus.ARADDR;
      req = toggle_req && !(rhs && bus.RLAST) && ($urandom_range(0, 1) == 1);
      if (rhs) beat++;
    end
    bus.ARREADY = 1'b0; bus.RVALID = 1'b0; bus.RLAST = 1'b0; req = 1'b0;
  endtask

  task automatic drive_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly,
                             input logic [1:0] resp);
    int          bw;
    bit          awk, wk, bk;
    logic        pav, pwv, prev_arv;
    logic [31:0] pa, pd;
    bw = 0; awk = 1'b0; wk = 1'b0; bk = 1'b0; pav = 1'b0; pwv = 1'b0; prev_arv = 1'b0;
    pa = '0; pd = '0;
    clear_obs();
    req = 1'b1; we = 1'b1; addr = a; wdata = d; wstrb = s;
    for (int c = 0; c < 300; c++) begin
      @(negedge ACLK);
      if (c == 0) o_busy0 = busy;
      if (bus.ARVALID && !prev_arv) o_ar_rise++;
      prev_arv = bus.ARVALID;
      if (pav && (!bus.AWVALID || bus.AWADDR !== pa)) o_viol++;
      if (pwv && (!bus.WVALID || bus.WDATA !== pd)) o_viol++;
      if (bus.WVALID && !bus.AWVALID) o_split++;
      if (done) begin
        o_done++; o_done_cyc = c; o_err = err;
        break;
      end
      bus.AWREADY = (c >= aw_dly) && !awk;
      bus.WREADY  = (c >= w_dly) && !wk;
      bus.BVALID  = awk && wk && !bk && (bw >= b_dly);
      bus.BRESP   = resp;
      if (awk && wk) bw++;
      if (bus.AWVALID && bus.AWREADY) begin
        awk = 1'b1; o_aw_cnt++;
        o_awaddr = bus.AWADDR; o_awlen = bus.AWLEN; o_awsize = bus.AWSIZE;
        o_awburst = bus.AWBURST; o_awid = bus.AWID;
      end
      if (bus.WVALID && bus.WREADY) begin
        wk = 1'b1; o_wdata = bus.WDATA; o_wstrb = bus.WSTRB; o_wlast = bus.WLAST;
      end
      if (bus.BVALID && bus.BREADY) bk = 1'b1;
      pav = bus.AWVALID && !bus.AWREADY; pa = bus.AWADDR;
      pwv = bus.WVALID && !bus.WREADY;   pd = bus.WDATA;
      req = 1'b0;
    end
    bus.AWREADY = 1'b0; bus.WREADY = 1'b0; bus.BVALID = 1'b0; req = 1'b0;
  endtask

  task automatic test_reset();
    ARESET = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    bus.ARREADY = 1'b0; bus.RVALID = 1'b0; bus.RLAST = 1'b0; bus.RDATA = '0; bus.RRESP = '0;
    bus.RID = '0; bus.AWREADY = 1'b0; bus.WREADY = 1'b0; bus.BVALID = 1'b0; bus.BRESP = '0;
    bus.BID = '0;
    repeat (2) @(negedge ACLK);
    n_cmp++;
    if ({busy, done, rdata_valid, err, bus.ARVALID, bus.RREADY, bus.AWVALID, bus.WVALID,
         bus.BREADY} !== 9'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 000000000", {busy, done, rdata_valid, err,
               bus.ARVALID, bus.RREADY, bus.AWVALID, bus.WVALID, bus.BREADY});
    end
    n_cmp++;
    if ({rdata, bus.ARADDR, bus.AWADDR} !== 96'h0) begin
      n_bad++;
      $display("FAIL reset_data: rdata %h araddr %h awaddr %h, want all 0", rdata, bus.ARADDR,
               bus.AWADDR);
    end
    ARESET = 1'b0;
    @(negedge ACLK);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle: busy %b want 0", busy); end
  endtask

  task automatic test_read_basic();
    fill_beats(LastBeat, 1'b0);
    bd[0] = 32'hDEAD_BEEF;
    drive_read(32'h0000_1004, 0, 0, 1'b0);
    n_cmp++;
    if (o_araddr !== exp_araddr(32'h1004)) begin
      n_bad++; $display("FAIL rd_araddr: got %h want %h", o_araddr, exp_araddr(32'h1004));
    end
    n_cmp++;
    if ({o_arid, o_arlen, o_arsize, o_arburst} !== {4'd0, 4'(LastBeat), 3'b010, 2'b01}) begin
      n_bad++;
      $display("FAIL rd_ar_attr: id %h len %h size %h burst %h", o_arid, o_arlen, o_arsize,
               o_arburst);
    end
    n_cmp++;
    if (rd_mismatch() != 0) begin
      n_bad++; $display("FAIL rd_data: %0d beats bad, got %0d beats want %0d", rd_mismatch(),
                        o_rd.size(), last_idx + 1);
    end
    n_cmp++;
    if (o_done !== 1 || o_done_cyc !== LastBeat + 2) begin
      n_bad++; $display("FAIL rd_done: count %0d cycle %0d want 1 at %0d", o_done, o_done_cyc,
                        LastBeat + 2);
    end
    n_cmp++;
    if ({o_err, o_busy0, o_viol != 0} !== 3'b010) begin
      n_bad++; $display("FAIL rd_status: err %b busy %b viol %0d want 0 1 0", o_err, o_busy0,
                        o_viol);
    end
  endtask

  task automatic test_write_backpressure();
    drive_write(32'h0000_2000, 32'h1234_5678, 4'b0011, 1, 3, 1, 2'b11);
    n_cmp++;
    if ({o_awaddr, o_wdata, o_wstrb} !== {32'h2000, 32'h1234_5678, 4'b0011}) begin
      n_bad++; $display("FAIL wr_payload: addr %h data %h strb %b", o_awaddr, o_wdata, o_wstrb);
    end
    n_cmp++;
    if ({o_awid, o_awlen, o_awsize, o_awburst, o_wlast} !== {4'd0, 4'd0, 3'b010, 2'b01, 1'b1})
    begin
      n_bad++; $display("FAIL wr_attr: id %h len %h size %h burst %h last %b", o_awid, o_awlen,
                        o_awsize, o_awburst, o_wlast);
    end
    n_cmp++;
    if (o_split !== 2 || o_viol !== 0) begin
      n_bad++; $display("FAIL wr_split: w-only cycles %0d viol %0d want 2 0", o_split, o_viol);
    end
    n_cmp++;
    if (o_done !== 1 || o_done_cyc !== 6 || o_err !== 1'b1) begin
      n_bad++; $display("FAIL wr_done: count %0d cycle %0d err %b want 1 6 1", o_done,
                        o_done_cyc, o_err);
    end
  endtask

  task automatic test_decerr_then_write();
    int held;
    fill_beats(LastBeat, 1'b0);
    br[0] = 2'b11;
    drive_read(32'h0000_5000, 1, 0, 1'b0);
    n_cmp++;
    if (o_done !== 1 || o_err !== 1'b1) begin
      n_bad++; $display("FAIL decerr_rd: done %0d err %b want 1 1", o_done, o_err);
    end
    held = 0;
    repeat (3) begin @(negedge ACLK); if (err === 1'b1) held++; end
    n_cmp++;
    if (held != 3) begin n_bad++; $display("FAIL decerr_hold: err high %0d/3 cycles", held); end
    drive_write(32'h0000_5004, $urandom, 4'hF, 0, 0, 0, 2'b00);
    n_cmp++;
    if (o_done !== 1 || o_err !== 1'b0 || o_done_cyc !== 2) begin
      n_bad++; $display("FAIL decerr_clear: done %0d err %b cycle %0d want 1 0 2", o_done,
                        o_err, o_done_cyc);
    end
  endtask

  task automatic test_beat_count();
    fill_beats(LastBeat, 1'b0);
    drive_read(32'h0000_3008, 0, 1, 1'b0);
    n_cmp++;
    if (o_araddr !== exp_araddr(32'h3008) || o_arlen !== 4'(LastBeat)) begin
      n_bad++; $display("FAIL fill_ar: addr %h len %h want %h %h", o_araddr, o_arlen,
                        exp_araddr(32'h3008), 4'(LastBeat));
    end
    n_cmp++;
    if (rd_mismatch() != 0 || o_done !== 1 || o_err !== 1'b0) begin
      n_bad++; $display("FAIL fill_beats: bad %0d done %0d err %b want 0 1 0", rd_mismatch(),
                        o_done, o_err);
    end
    fill_beats(1, 1'b0);
    drive_read(32'h0000_3008, 0, 1, 1'b0);
    n_cmp++;
    if (rd_mismatch() != 0 || o_done !== 1 || o_err !== 1'b1) begin
      n_bad++; $display("FAIL early_last: bad %0d done %0d err %b want 0 1 1", rd_mismatch(),
                        o_done, o_err);
    end
  endtask

  task automatic test_ignored_req();
    fill_beats(LastBeat, 1'b0);
    drive_read(32'h0000_6000, 2, 2, 1'b1);
    n_cmp++;
    if (o_ar_rise !== 1 || o_aw_cnt !== 0 || o_done !== 1) begin
      n_bad++; $display("FAIL ignored_req: ar rises %0d aw cycles %0d done %0d want 1 0 1",
                        o_ar_rise, o_aw_cnt, o_done);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      fill_beats(LastBeat, 1'b0);
      drive_read(32'h0000_7000 + 32'(i * 16), 0, 0, 1'b0);
      n_cmp++;
      if (o_done !== 1 || o_done_cyc !== LastBeat + 2 || rd_mismatch() != 0) begin
        n_bad++; $display("FAIL b2b_rd%0d: done %0d cycle %0d bad %0d", i, o_done, o_done_cyc,
                          rd_mismatch());
      end
    end
    drive_write(32'h0000_7100, $urandom, 4'hF, 0, 0, 0, 2'b00);
    n_cmp++;
    if (o_done !== 1 || o_done_cyc !== 2) begin
      n_bad++; $display("FAIL b2b_wr: done %0d cycle %0d want 1 2", o_done, o_done_cyc);
    end
  endtask

  task automatic test_reset_mid_read();
    int extra;
    req = 1'b1; we = 1'b0; addr = 32'h0000_4000;
    @(negedge ACLK); req = 1'b0; bus.ARREADY = 1'b1;
    @(negedge ACLK); bus.ARREADY = 1'b0;
    n_cmp++;
    if (bus.RREADY !== 1'b1) begin n_bad++; $display("FAIL mid_rready: got %b want 1", bus.RREADY); end
    #1 ARESET = 1'b1;
    #1;
    n_cmp++;
    if ({bus.RREADY, busy, bus.ARVALID, done, rdata_valid} !== 5'b0 || rdata !== 32'h0) begin
      n_bad++; $display("FAIL mid_reset: rready/busy/arvalid/done/rv %b rdata %h want 0",
                        {bus.RREADY, busy, bus.ARVALID, done, rdata_valid}, rdata);
    end
    @(negedge ACLK); ARESET = 1'b0;
    extra = 0;
    bus.RVALID = 1'b1; bus.RLAST = 1'b1; bus.RDATA = $urandom; bus.RRESP = 2'b00;
    repeat (4) begin @(negedge ACLK); if (done || rdata_valid || busy) extra++; end
    bus.RVALID = 1'b0; bus.RLAST = 1'b0;
    n_cmp++;
    if (extra != 0) begin n_bad++; $display("FAIL mid_no_done: %0d active cycles want 0", extra); end
    fill_beats(LastBeat, 1'b0);
    drive_read(32'h0000_4010, 1, 0, 1'b0);
    n_cmp++;
    if (o_done !== 1 || o_err !== 1'b0 || rd_mismatch() != 0) begin
      n_bad++; $display("FAIL mid_recover: done %0d err %b bad %0d", o_done, o_err, rd_mismatch());
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic [3:0]  s;
    logic [1:0]  resp;
    int          ad, wd, bdl, li, rm, mx;
    for (int it = 0; it < 30; it++) begin
      a = $urandom; a[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 1) begin
        li = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : LastBeat;
        fill_beats(li, 1'b1);
        ad = $urandom_range(0, 3);
        rm = ($urandom_range(0, 1) == 1) ? 2 : 0;
        drive_read(a, ad, rm, 1'b0);
        n_cmp++;
        if (o_araddr !== exp_araddr(a) || rd_mismatch() != 0) begin
          n_bad++; $display("FAIL rand_rd%0d: addr %h want %h, %0d beats bad", it, o_araddr,
                            exp_araddr(a), rd_mismatch());
        end
        n_cmp++;
        if (o_done !== 1 || o_err !== exp_rerr() || o_viol !== 0) begin
          n_bad++; $display("FAIL rand_rd%0d_st: done %0d err %b want 1 %b viol %0d", it,
                            o_done, o_err, exp_rerr(), o_viol);
        end
        if (rm == 0) begin
          n_cmp++;
          if (o_done_cyc !== ad + li + 2) begin
            n_bad++; $display("FAIL rand_rd%0d_lat: cycle %0d want %0d", it, o_done_cyc,
                              ad + li + 2);
          end
        end
      end else begin
        d = $urandom; s = 4'($urandom); resp = 2'($urandom);
        ad = $urandom_range(0, 3); wd = $urandom_range(0, 3); bdl = $urandom_range(0, 2);
        mx = (ad > wd) ? ad : wd;
        drive_write(a, d, s, ad, wd, bdl, resp);
        n_cmp++;
        if ({o_awaddr, o_wdata, o_wstrb} !== {a, d, s} || o_viol !== 0) begin
          n_bad++; $display("FAIL rand_wr%0d: addr %h data %h strb %b want %h %h %b viol %0d",
                            it, o_awaddr, o_wdata, o_wstrb, a, d, s, o_viol);
        end
        n_cmp++;
        if (o_done !== 1 || o_err !== (resp != 2'b00) || o_done_cyc !== mx + bdl + 2 ||
            o_split !== ((wd > ad) ? wd - ad : 0)) begin
          n_bad++; $display("FAIL rand_wr%0d_st: done %0d err %b cyc %0d split %0d", it, o_done,
                            o_err, o_done_cyc, o_split);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_backpressure();
    test_decerr_then_write();
    test_beat_count();
    test_ignored_req();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached with %0d compared", n_cmp);
    $fatal(1, "simulation time limit");
  end

endmodule
